// File: rtl/snn_sched_pkg.sv
// rtl/snn_sched_pkg.sv - shared state encoding, width defaults and layer-select constants for snn_step_scheduler
package snn_sched_pkg;

    localparam int SPIKE_W_DEF = 24;
    localparam int DIV_W_DEF   = 8;

    localparam logic [1:0] LAYER_SEL_NONE   = 2'b00;
    localparam logic [1:0] LAYER_SEL_HIDDEN = 2'b01;
    localparam logic [1:0] LAYER_SEL_OUTPUT = 2'b10;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        L1   = 3'd2,
        L2   = 3'd3,
        DONE = 3'd4
    } sched_state_t;

endpackage

// File: rtl/flag_sync_edge.sv
// rtl/flag_sync_edge.sv - brings an SCLK-domain level flag into clk and pulses on its rising edge
module flag_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_flag,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_flag};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/snn_step_scheduler.sv
// rtl/snn_step_scheduler.sv - SNN timestep sequencer: tick divider, frame latch, layer enables; SCHED_STEP_COUNT_EN adds step_count
module snn_step_scheduler
    import snn_sched_pkg::*;
#(
    parameter int SPIKE_W      = SPIKE_W_DEF,
    parameter int DIV_W        = DIV_W_DEF,
    parameter int LAYER_CYCLES = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clk_div_ready,
    input  logic               input_spike_ready,
    input  logic [DIV_W-1:0]   div_value,
    input  logic [SPIKE_W-1:0] input_spikes,
    input  logic               run_en,
    output logic [SPIKE_W-1:0] spikes_latched,
    output logic               spike_load,
    output logic [1:0]         layer_en,
    output logic               step_done,
    output logic               busy,
    output logic               tick,
    output logic               overrun,
    output logic [CNT_W-1:0]   step_count
);

    localparam int              LC_W    = $clog2(LAYER_CYCLES + 1);
    localparam logic [LC_W-1:0] LC_LAST = LC_W'(LAYER_CYCLES - 1);

    logic               w_div_rise;
    logic               w_spk_rise;
    logic               w_tick;

    logic [DIV_W-1:0]   r_cnt;
    logic [DIV_W-1:0]   r_div_q;
    logic               r_pending;
    logic               r_overrun;
    sched_state_t       r_state;
    logic [LC_W-1:0]    r_lcnt;
    logic [SPIKE_W-1:0] r_spikes;
    logic               r_spike_load;
    logic [1:0]         r_layer_en;
    logic               r_step_done;
    logic               r_busy;

    flag_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_div_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_flag (clk_div_ready),
        .o_rise (w_div_rise)
    );

    flag_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_spk_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_flag (input_spike_ready),
        .o_rise (w_spk_rise)
    );

    // A divider reload restarts the period, so the tick it would have produced is dropped.
    assign w_tick = (r_cnt == r_div_q) && !w_div_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_div_q   <= '1;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_div_rise) begin
                r_div_q <= div_value;
                r_cnt   <= '0;
            end else if (r_cnt == r_div_q) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_div_rise) begin
                r_overrun <= 1'b0;
            end else if (w_tick && r_busy && r_pending) begin
                r_overrun <= 1'b1;
            end

            // A frame arriving in the LOAD cycle is a new frame and must survive the clear.
            if (w_spk_rise) begin
                r_pending <= 1'b1;
            end else if (r_state == LOAD) begin
                r_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_lcnt       <= '0;
            r_spikes     <= '0;
            r_spike_load <= 1'b0;
            r_layer_en   <= LAYER_SEL_NONE;
            r_step_done  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_tick && run_en && r_pending) begin
                        r_state      <= LOAD;
                        r_spikes     <= input_spikes;
                        r_spike_load <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                LOAD: begin
                    r_state      <= L1;
                    r_spike_load <= 1'b0;
                    r_layer_en   <= LAYER_SEL_HIDDEN;
                    r_lcnt       <= '0;
                end
                L1: begin
                    if (r_lcnt == LC_LAST) begin
                        r_state    <= L2;
                        r_layer_en <= LAYER_SEL_OUTPUT;
                        r_lcnt     <= '0;
                    end else begin
                        r_lcnt <= r_lcnt + 1'b1;
                    end
                end
                L2: begin
                    if (r_lcnt == LC_LAST) begin
                        r_state     <= DONE;
                        r_layer_en  <= LAYER_SEL_NONE;
                        r_step_done <= 1'b1;
                        r_lcnt      <= '0;
                    end else begin
                        r_lcnt <= r_lcnt + 1'b1;
                    end
                end
                DONE: begin
                    r_state     <= IDLE;
                    r_step_done <= 1'b0;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_state      <= IDLE;
                    r_spike_load <= 1'b0;
                    r_layer_en   <= LAYER_SEL_NONE;
                    r_step_done  <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

`ifdef SCHED_STEP_COUNT_EN
    logic [CNT_W-1:0] r_step_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step_count <= '0;
        end else if (r_state == DONE) begin
            r_step_count <= r_step_count + 1'b1;
        end
    end

    assign step_count = r_step_count;
`else
    assign step_count = '0;
`endif

    assign spikes_latched = r_spikes;
    assign spike_load     = r_spike_load;
    assign layer_en       = r_layer_en;
    assign step_done      = r_step_done;
    assign busy           = r_busy;
    assign tick           = w_tick;
    assign overrun        = r_overrun;

endmodule

// File: tb/tb_snn_step_scheduler.sv
// tb/tb_snn_step_scheduler.sv - self-checking bench for snn_step_scheduler (phase-position model plus directed literals)
module tb_snn_step_scheduler;

    localparam int SS = 2;
    localparam int LC = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clk_div_ready;
    logic        input_spike_ready;
    logic [7:0]  div_value;
    logic [23:0] input_spikes;
    logic        run_en;
    logic [23:0] spikes_latched;
    logic        spike_load;
    logic [1:0]  layer_en;
    logic        step_done;
    logic        busy;
    logic        tick;
    logic        overrun;
    logic [15:0] step_count;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    snn_step_scheduler dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .clk_div_ready     (clk_div_ready),
        .input_spike_ready (input_spike_ready),
        .div_value         (div_value),
        .input_spikes      (input_spikes),
        .run_en            (run_en),
        .spikes_latched    (spikes_latched),
        .spike_load        (spike_load),
        .layer_en          (layer_en),
        .step_done         (step_done),
        .busy              (busy),
        .tick              (tick),
        .overrun           (overrun),
        .step_count        (step_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_pos is the position inside a step (-1 idle, 0 load, 1..2LC layers, 2LC+1 done).
    int          m_cnt   = 0;
    int          m_divq  = 255;
    int          m_pos   = -1;
    bit          m_pend  = 0;
    bit          m_ovr   = 0;
    logic [23:0] m_lat   = '0;
    int          m_steps = 0;
    bit          pd [1:SS+1];
    bit          ps [1:SS+1];
    bit          m_drise, m_srise, m_t;
    int          m_old;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_divq = 255; m_pos = -1; m_pend = 0; m_ovr = 0; m_lat = '0; m_steps = 0;
            for (int i = 1; i <= SS + 1; i++) begin pd[i] = 0; ps[i] = 0; end
        end else begin
            m_drise = pd[SS] && !pd[SS+1];
            m_srise = ps[SS] && !ps[SS+1];
            m_t     = (m_cnt == m_divq) && !m_drise;
            m_old   = m_pos;
            if (m_drise) begin m_divq = div_value; m_cnt = 0; m_ovr = 0; end
            else if (m_cnt == m_divq) m_cnt = 0;
            else m_cnt = m_cnt + 1;
            if (m_t && m_old >= 0 && m_pend) m_ovr = 1;
            if (m_old < 0) begin
                if (m_t && run_en && m_pend) begin m_pos = 0; m_lat = input_spikes; end
            end else if (m_old == 2 * LC + 1) begin
                m_pos = -1; m_steps = (m_steps + 1) % 65536;
            end else begin
                m_pos = m_pos + 1;
            end
            if (m_old == 0) m_pend = 0;
            if (m_srise) m_pend = 1;
            for (int i = SS + 1; i > 1; i--) begin pd[i] = pd[i-1]; ps[i] = ps[i-1]; end
            pd[1] = clk_div_ready;
            ps[1] = input_spike_ready;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_tick", tick, (m_cnt == m_divq) && !(pd[SS] && !pd[SS+1]));
            chk("cyc_spike_load", spike_load, m_pos == 0);
            chk("cyc_latched", spikes_latched, m_lat);
            chk("cyc_layer_en", layer_en, (m_pos >= 1 && m_pos <= LC) ? 2'b01 :
                                          (m_pos > LC && m_pos <= 2 * LC) ? 2'b10 : 2'b00);
            chk("cyc_step_done", step_done, m_pos == 2 * LC + 1);
            chk("cyc_busy", busy, m_pos >= 0);
            chk("cyc_overrun", overrun, m_ovr);
`ifdef SCHED_STEP_COUNT_EN
            chk("cyc_step_count", step_count, m_steps);
`else
            chk("cyc_step_count", step_count, 0);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_load(input int bound, output bit prev_tick);
        bit t;
        bit ok;
        ok = 0;
        prev_tick = 0;
        for (int i = 0; i < bound; i++) begin
            t = tick;
            cyc();
            if (spike_load) begin
                prev_tick = t;
                ok = 1;
                break;
            end
        end
        chk("load_within_bound", ok, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit pt;
        int loads, ticks, first, dones;
        clk_div_ready = 0; input_spike_ready = 0; div_value = 0; input_spikes = 0; run_en = 0;
        #1 rst_n = 0;
        #1 chk_en = 1;
        repeat (3) cyc();
        chk("rst_busy", busy, 0);
        chk("rst_layer_en", layer_en, 0);
        chk("rst_tick", tick, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_latched", spikes_latched, 0);
        chk("rst_step_count", step_count, 0);
        rst_n = 1;
        cyc();

        // divider: first tick 6 cycles after the flag rises, then every 4
        div_value = 8'd3;
        clk_div_ready = 1;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            chk("div_tick_phase", tick, (k == 6 || k == 10));
        end

        // single frame step
        input_spikes = 24'hFEDCBA;
        input_spike_ready = 1;
        run_en = 1;
        wait_load(20, pt);
        chk("step_prev_tick", pt, 1);
        chk("step_latched", spikes_latched, 24'hFEDCBA);
        for (int j = 1; j <= 9; j++) begin
            cyc();
            chk("step_layer_en", layer_en, (j <= 4) ? 2'b01 : (j <= 8) ? 2'b10 : 2'b00);
            chk("step_done_pos", step_done, j == 9);
        end
        cyc();
        chk("step_idle_busy", busy, 0);
        input_spike_ready = 0;
        repeat (4) cyc();

        // overrun with div=0 and a second frame arriving during the step
        div_value = 8'd0;
        clk_div_ready = 0;
        repeat (4) cyc();
        clk_div_ready = 1;
        repeat (4) cyc();
        chk("ovr_cleared", overrun, 0);
        input_spikes = 24'h123456;
        input_spike_ready = 1;
        wait_load(10, pt);
        chk("ovr_first_frame", spikes_latched, 24'h123456);
        repeat (2) cyc();
        input_spike_ready = 0;
        repeat (3) cyc();
        input_spikes = 24'hABCDEF;
        input_spike_ready = 1;
        wait_load(12, pt);
        chk("ovr_second_frame", spikes_latched, 24'hABCDEF);
        chk("ovr_sticky", overrun, 1);
        repeat (10) cyc();
        input_spike_ready = 0;
        run_en = 0;

        // run_en low holds the pending frame; ticks keep running
        div_value = 8'd3;
        clk_div_ready = 0;
        repeat (4) cyc();
        clk_div_ready = 1;
        repeat (4) cyc();
        chk("run_ovr_cleared", overrun, 0);
        input_spikes = 24'h0F0F0F;
        input_spike_ready = 1;
        loads = 0; ticks = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            loads += spike_load;
            ticks += tick;
        end
        chk("run_no_load", loads, 0);
        chk("run_ticks", ticks, 5);
        run_en = 1;
        wait_load(8, pt);
        chk("run_prev_tick", pt, 1);
        chk("run_latched", spikes_latched, 24'h0F0F0F);
        repeat (10) cyc();
        input_spike_ready = 0;
        repeat (4) cyc();

        // reset in L2 aborts the step and restores div_q
        input_spikes = 24'h555555;
        input_spike_ready = 1;
        wait_load(10, pt);
        repeat (6) cyc();
        chk("rst_mid_in_l2", layer_en, 2'b10);
        rst_n = 0;
        clk_div_ready = 0;
        input_spike_ready = 0;
        #1;
        chk("rst_mid_layer_en", layer_en, 0);
        chk("rst_mid_busy", busy, 0);
        repeat (2) cyc();
        rst_n = 1;
        first = 0; dones = 0;
        for (int n = 1; n <= 300; n++) begin
            cyc();
            dones += step_done;
            if (tick) begin first = n; break; end
        end
        chk("rst_first_tick", first, 255);
        chk("rst_no_step_done", dones, 0);

        // five steps for the step counter
        div_value = 8'd0;
        clk_div_ready = 1;
        repeat (4) cyc();
        chk("cnt_start", step_count, 0);
        for (int s = 0; s < 5; s++) begin
            input_spikes = 24'h100000 + 24'(s);
            input_spike_ready = 1;
            wait_load(10, pt);
            chk("cnt_frame", spikes_latched, 24'h100000 + 24'(s));
            repeat (10) cyc();
            input_spike_ready = 0;
            repeat (4) cyc();
        end
`ifdef SCHED_STEP_COUNT_EN
        chk("cnt_five", step_count, 5);
`else
        chk("cnt_tied_zero", step_count, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
